// File: rtl/io_map_pkg.sv
// io_map_pkg: shared definitions for the port-mapped I/O responder.
//   - Port IDs for every readable/writable location on the MCU I/O bus.
//   - Bit positions inside the timer CTRL write byte.
//   - Timer state encoding, also exported as a debug/status signal.
// Optional feature macro referenced by users of this package: TIMER_PRESCALE_EN
package io_map_pkg;

  // Write-side IDs
  localparam logic [7:0] PID_LEDS     = 8'h40;
  localparam logic [7:0] PID_SSEG     = 8'h41;
  localparam logic [7:0] PID_TMR_LO   = 8'h50;
  localparam logic [7:0] PID_TMR_HI   = 8'h51;
  localparam logic [7:0] PID_TMR_CTRL = 8'h52;  // also the status read ID
  localparam logic [7:0] PID_BTN_CLR  = 8'h53;
  localparam logic [7:0] PID_TMR_PRE  = 8'h55;  // only mapped with TIMER_PRESCALE_EN

  // Read-side IDs
  localparam logic [7:0] PID_SWITCHES = 8'hFF;
  localparam logic [7:0] PID_BUTTONS  = 8'hFE;
  localparam logic [7:0] PID_TMR_CNT  = 8'h54;

  // CTRL byte bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_ACK  = 2;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_t;

endpackage

// File: rtl/io_port_responder_if.sv
// io_port_responder_if: MCU port-mapped I/O bus.
//   PORT_ID  : port address driven by the MCU
//   OUT_PORT : write data driven by the MCU
//   IO_STRB  : write strobe, driven by the MCU
//   IN_PORT  : read data returned by the responder
//   INT_R    : level interrupt request returned by the responder
// Transfer rules: a write is accepted on every rising clock edge where
// IO_STRB=1; there is no ready/back-pressure, the responder always accepts,
// and IO_STRB is high for exactly one cycle per OUT instruction. Reads are
// combinational: IN_PORT reflects PORT_ID in the same cycle and has no side
// effects.
interface io_port_responder_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_PORT;
  logic       INT_R;

  modport master (output PORT_ID, OUT_PORT, IO_STRB, input IN_PORT, INT_R);
  modport slave  (input PORT_ID, OUT_PORT, IO_STRB, output IN_PORT, INT_R);
endinterface

// File: rtl/io_timer.sv
// io_timer: programmable down-counter with sticky expiry flag.
//   clk, rst         : clock, async active-high reset
//   wr_lo/wr_hi      : decoded writes of reload[7:0] / reload[TIMER_W-1:8]
//   wr_ctrl          : decoded CTRL write (EN / AUTO / ACK)
//   wr_pre, prescale : prescale register write / value (TIMER_PRESCALE_EN only)
//   wr_data          : write data byte
//   count_lo         : count[7:0] for the read mux
//   autoreload       : stored AUTO bit
//   expired          : sticky expiry flag (interrupt source)
//   state            : TMR_IDLE / TMR_RUN, the timer state (running flag)
// Optional feature: TIMER_PRESCALE_EN adds an 8-bit prescaler so the timer
// steps once every prescale+1 cycles.
module io_timer
  import io_map_pkg::*;
#(
  parameter int TIMER_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_lo,
  input  logic       wr_hi,
  input  logic       wr_ctrl,
`ifdef TIMER_PRESCALE_EN
  input  logic       wr_pre,
  output logic [7:0] prescale,
`endif
  input  logic [7:0] wr_data,
  output logic [7:0] count_lo,
  output logic       autoreload,
  output logic       expired,
  output tmr_state_t state
);

  logic [TIMER_W-1:0] reload;
  logic [TIMER_W-1:0] count;
  logic step;
  logic tick;
  logic at_zero;
  logic expire_now;

`ifdef TIMER_PRESCALE_EN
  logic [7:0] pre_cnt;
  // The timer advances only on the cycle the prescale counter wraps.
  assign step = (pre_cnt == prescale);
`else
  assign step = 1'b1;
`endif

  assign tick       = (state == TMR_RUN) && step;
  assign at_zero    = (count == '0);
  assign expire_now = tick && at_zero;
  assign count_lo   = count[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload     <= '0;
      count      <= '0;
      state      <= TMR_IDLE;
      autoreload <= 1'b0;
      expired    <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      prescale   <= 8'h00;
      pre_cnt    <= 8'h00;
`endif
    end else begin
      // Reload writes never touch the in-flight count.
      if (wr_lo) reload[7:0] <= wr_data;
      if (wr_hi) reload[TIMER_W-1:8] <= wr_data[TIMER_W-9:0];

`ifdef TIMER_PRESCALE_EN
      if (wr_pre) prescale <= wr_data;
      if (state == TMR_RUN) pre_cnt <= step ? 8'h00 : pre_cnt + 8'h01;
`endif

      if (tick) begin
        if (!at_zero) begin
          count <= count - TIMER_W'(1);
        end else begin
          expired <= 1'b1;
          if (autoreload) count <= reload;
          else            state <= TMR_IDLE;
        end
      end

      // CTRL is applied after the step so EN/stop override the count update;
      // an expiry in the same cycle beats ACK.
      if (wr_ctrl) begin
        autoreload <= wr_data[CTRL_AUTO];
        if (wr_data[CTRL_ACK] && !expire_now) expired <= 1'b0;
        if (wr_data[CTRL_EN]) begin
          count <= reload;
          state <= TMR_RUN;
`ifdef TIMER_PRESCALE_EN
          pre_cnt <= 8'h00;
`endif
        end else begin
          count <= count;
          state <= TMR_IDLE;
        end
      end
    end
  end

endmodule

// File: rtl/io_port_responder.sv
// io_port_responder: peripheral side of the MCU port-mapped I/O bus.
//   CLK, RESET : clock, async active-high reset
//   bus        : io_port_responder_if.slave (PORT_ID, OUT_PORT, IO_STRB in;
//                IN_PORT, INT_R out)
//   SWITCHES   : quasi-static board switches (read at 0xFF)
//   BUTTONS    : raw async pushbuttons, synchronized and edge-latched (0xFE)
//   LEDS       : LED register (0x40)
//   SSEG_DATA  : seven-segment register (0x41)
// Timer lives in io_timer. Optional feature macro: TIMER_PRESCALE_EN
// (adds prescale register at 0x55).
// TIMER_W must be 9..16; SYNC_STAGES must be >= 2.
module io_port_responder
  import io_map_pkg::*;
#(
  parameter int TIMER_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  io_port_responder_if.slave  bus,
  input  logic [7:0]          SWITCHES,
  input  logic [3:0]          BUTTONS,
  output logic [7:0]          LEDS,
  output logic [7:0]          SSEG_DATA
);

  logic wr_leds, wr_sseg, wr_lo, wr_hi, wr_ctrl, wr_btn_clr;
  assign wr_leds    = bus.IO_STRB && (bus.PORT_ID == PID_LEDS);
  assign wr_sseg    = bus.IO_STRB && (bus.PORT_ID == PID_SSEG);
  assign wr_lo      = bus.IO_STRB && (bus.PORT_ID == PID_TMR_LO);
  assign wr_hi      = bus.IO_STRB && (bus.PORT_ID == PID_TMR_HI);
  assign wr_ctrl    = bus.IO_STRB && (bus.PORT_ID == PID_TMR_CTRL);
  assign wr_btn_clr = bus.IO_STRB && (bus.PORT_ID == PID_BTN_CLR);

  logic [7:0] count_lo;
  logic       autoreload;
  logic       expired;
  tmr_state_t tmr_state;
`ifdef TIMER_PRESCALE_EN
  logic       wr_pre;
  logic [7:0] prescale;
  assign wr_pre = bus.IO_STRB && (bus.PORT_ID == PID_TMR_PRE);
`endif

  io_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk        (CLK),
    .rst        (RESET),
    .wr_lo      (wr_lo),
    .wr_hi      (wr_hi),
    .wr_ctrl    (wr_ctrl),
`ifdef TIMER_PRESCALE_EN
    .wr_pre     (wr_pre),
    .prescale   (prescale),
`endif
    .wr_data    (bus.OUT_PORT),
    .count_lo   (count_lo),
    .autoreload (autoreload),
    .expired    (expired),
    .state      (tmr_state)
  );

  // Button synchronizer, rising-edge detect and sticky latch.
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] btn_prev;
  logic [3:0] btn_latch;
  logic [3:0] btn_rise;
  logic [3:0] clr_mask;

  assign btn_rise = sync_q[SYNC_STAGES-1] & ~btn_prev;
  assign clr_mask = wr_btn_clr ? bus.OUT_PORT[3:0] : 4'h0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'h0;
      btn_prev  <= 4'h0;
      btn_latch <= 4'h0;
      LEDS      <= 8'h00;
      SSEG_DATA <= 8'h00;
    end else begin
      sync_q[0] <= BUTTONS;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      btn_prev  <= sync_q[SYNC_STAGES-1];
      // OR-ing the rise after the clear lets a same-cycle edge win.
      btn_latch <= (btn_latch & ~clr_mask) | btn_rise;
      if (wr_leds) LEDS      <= bus.OUT_PORT;
      if (wr_sseg) SSEG_DATA <= bus.OUT_PORT;
    end
  end

  logic [7:0] rd_data;
  always_comb begin
    rd_data = 8'h00;
    case (bus.PORT_ID)
      PID_SWITCHES: rd_data = SWITCHES;
      PID_BUTTONS:  rd_data = {4'h0, btn_latch};
      PID_TMR_CTRL: rd_data = {5'b0, autoreload, (tmr_state == TMR_RUN), expired};
      PID_TMR_CNT:  rd_data = count_lo;
`ifdef TIMER_PRESCALE_EN
      PID_TMR_PRE:  rd_data = prescale;
`endif
      default:      rd_data = 8'h00;
    endcase
  end

  assign bus.IN_PORT = rd_data;
  assign bus.INT_R   = expired;  // straight from the flop

endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder: directed + randomized bench for io_port_responder.
// Expected values come from a small behavioural model: register shadows,
// a button-latch bit set, and timer latency computed as (reload+1)*(pre+1).
module tb_io_port_responder;
  localparam int SYNC = 2;

  logic       CLK;
  logic       RESET;
  logic [7:0] SWITCHES;
  logic [3:0] BUTTONS;
  logic [7:0] LEDS;
  logic [7:0] SSEG_DATA;

  io_port_responder_if bus ();

  io_port_responder #(.TIMER_W(16), .SYNC_STAGES(SYNC)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus.slave),
    .SWITCHES  (SWITCHES),
    .BUTTONS   (BUTTONS),
    .LEDS      (LEDS),
    .SSEG_DATA (SSEG_DATA)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // model state
  logic [7:0] leds_m, sseg_m;
  logic [3:0] btn_m;

  task automatic tick_();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] data);
    bus.PORT_ID  = id;
    bus.OUT_PORT = data;
    bus.IO_STRB  = 1'b1;
    tick_();
    bus.IO_STRB  = 1'b0;
    bus.PORT_ID  = 8'h00;
  endtask

  task automatic rd(input logic [7:0] id, output logic [7:0] d);
    bus.PORT_ID = id;
    #1;
    d = bus.IN_PORT;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edges counted after the write edge until INT_R is seen high.
  task automatic wait_int(input int budget, output int n);
    n = 0;
    while (bus.INT_R !== 1'b1 && n < budget) begin
      tick_();
      n++;
    end
  endtask

  task automatic check_rd(input string tag, input logic [7:0] id, input logic [7:0] exp);
    logic [7:0] d;
    rd(id, d);
    check(tag, {24'h0, d}, {24'h0, exp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int r;
    logic [7:0] d;
    logic [7:0] id_tab [6];
    logic [7:0] id;
    logic       strb;
    logic [3:0] b;
    logic [3:0] c;
    logic [15:0] cnt_m;

    id_tab[0] = 8'h40; id_tab[1] = 8'h41; id_tab[2] = 8'h99;
    id_tab[3] = 8'h00; id_tab[4] = 8'h42; id_tab[5] = 8'h3F;

    RESET = 1'b1;
    bus.PORT_ID = 8'h00; bus.OUT_PORT = 8'h00; bus.IO_STRB = 1'b0;
    SWITCHES = 8'h00; BUTTONS = 4'h0;
    leds_m = 8'h00; sseg_m = 8'h00; btn_m = 4'h0;
    repeat (3) tick_();
    RESET = 1'b0;
    tick_();

    // reset state
    check("rst_leds", LEDS, 0);
    check("rst_sseg", SSEG_DATA, 0);
    check("rst_int", bus.INT_R, 0);
    check_rd("rst_status", 8'h52, 8'h00);
    check_rd("rst_count", 8'h54, 8'h00);
    check_rd("rst_btn", 8'hFE, 8'h00);

    // write decode
    wr(8'h40, 8'hA5); leds_m = 8'hA5;
    check("leds_a5", LEDS, leds_m);
    wr(8'h41, 8'h3C); sseg_m = 8'h3C;
    check("sseg_3c", SSEG_DATA, sseg_m);
    wr(8'h99, 8'hFF);
    check("unmapped_leds", LEDS, leds_m);
    check("unmapped_sseg", SSEG_DATA, sseg_m);
    bus.PORT_ID = 8'h40; bus.OUT_PORT = 8'h11; bus.IO_STRB = 1'b0;
    tick_();
    check("nostrb_leds", LEDS, leds_m);

    // random register traffic
    for (int i = 0; i < 16; i++) begin
      id   = id_tab[$urandom_range(0, 5)];
      d    = 8'($urandom);
      strb = ($urandom_range(0, 3) != 0);
      bus.PORT_ID = id; bus.OUT_PORT = d; bus.IO_STRB = strb;
      tick_();
      bus.IO_STRB = 1'b0;
      if (strb && id == 8'h40) leds_m = d;
      if (strb && id == 8'h41) sseg_m = d;
      check("rnd_leds", LEDS, leds_m);
      check("rnd_sseg", SSEG_DATA, sseg_m);
    end

    // switches and unmapped reads
    SWITCHES = 8'h5A;
    check_rd("sw_5a", 8'hFF, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      SWITCHES = 8'($urandom);
      check_rd("sw_rnd", 8'hFF, SWITCHES);
    end
    check_rd("unmapped_rd", 8'h77, 8'h00);
`ifndef TIMER_PRESCALE_EN
    wr(8'h55, 8'h37);
    check_rd("pre_unmapped", 8'h55, 8'h00);
`endif

    // one-shot, reload 4
    wr(8'h50, 8'h04); wr(8'h51, 8'h00); wr(8'h52, 8'h01);
    wait_int(64, n);
    check("oneshot_lat", n, 5);
    check_rd("oneshot_status", 8'h52, 8'h01);
    check_rd("oneshot_count", 8'h54, 8'h00);
    wr(8'h52, 8'h04);
    check("ack_int", bus.INT_R, 0);
    check_rd("ack_status", 8'h52, 8'h00);

    // random one-shot latencies
    for (int i = 0; i < 5; i++) begin
      r = $urandom_range(0, 12);
      wr(8'h50, 8'(r)); wr(8'h51, 8'h00); wr(8'h52, 8'h01);
      wait_int(64, n);
      check("rnd_oneshot_lat", n, r + 1);
      wr(8'h52, 8'h04);
      check("rnd_ack", bus.INT_R, 0);
    end

    // 16-bit reload, count readback, reload write while running, stop/hold
    cnt_m = 16'h0102;
    wr(8'h50, 8'h02); wr(8'h51, 8'h01); wr(8'h52, 8'h01);
    check_rd("cnt_start", 8'h54, cnt_m[7:0]);
    repeat (3) tick_();
    cnt_m = cnt_m - 16'd3;
    check_rd("cnt_after3", 8'h54, cnt_m[7:0]);
    check_rd("run_status", 8'h52, 8'h02);
    wr(8'h50, 8'h80);
    cnt_m = cnt_m - 16'd1;
    check_rd("cnt_reload_wr", 8'h54, cnt_m[7:0]);
    wr(8'h52, 8'h00);
    repeat (2) tick_();
    check_rd("cnt_held", 8'h54, cnt_m[7:0]);
    check_rd("stop_status", 8'h52, 8'h00);
    wr(8'h52, 8'h01);
    check_rd("cnt_new_reload", 8'h54, 8'h80);
    wr(8'h52, 8'h00);
    check("no_exp_int", bus.INT_R, 0);

    // auto-reload period 3 and ACK collision
    wr(8'h50, 8'h02); wr(8'h51, 8'h00); wr(8'h52, 8'h03);  // E0
    tick_(); tick_();
    check("auto_e2", bus.INT_R, 0);
    tick_();
    check("auto_e3", bus.INT_R, 1);
    check_rd("auto_status", 8'h52, 8'h07);
    wr(8'h52, 8'h07);                                      // E4 restart+ack
    check("auto_ack_clr", bus.INT_R, 0);
    tick_(); tick_();
    check("auto_e6", bus.INT_R, 0);
    wr(8'h52, 8'h07);                                      // E7 = expiry
    check("ack_collision", bus.INT_R, 1);
    wr(8'h52, 8'h07);                                      // E8
    check("ack_after_coll", bus.INT_R, 0);
    tick_(); tick_();
    check("auto_e10", bus.INT_R, 0);
    tick_();
    check("auto_e11", bus.INT_R, 1);
    repeat (3) tick_();
    check("sticky", bus.INT_R, 1);
    wr(8'h52, 8'h04);
    check("auto_stop_ack", bus.INT_R, 0);
    check_rd("auto_stop_status", 8'h52, 8'h00);

    // reload 0 with AUTO: expires every cycle
    wr(8'h50, 8'h00); wr(8'h52, 8'h03);
    tick_();
    check("r0_e1", bus.INT_R, 1);
    wr(8'h52, 8'h07);
    check("r0_collision", bus.INT_R, 1);
    wr(8'h52, 8'h00);
    wr(8'h52, 8'h04);
    check("r0_cleared", bus.INT_R, 0);

    // buttons
    BUTTONS = 4'b0100;
    repeat (SYNC) tick_();
    check_rd("btn_early", 8'hFE, btn_m);
    tick_();
    btn_m[2] = 1'b1;
    check_rd("btn_set", 8'hFE, btn_m);
    BUTTONS = 4'h0;
    repeat (4) tick_();
    check_rd("btn_hold", 8'hFE, btn_m);
    wr(8'h53, 8'h04); btn_m[2] = 1'b0;
    check_rd("btn_clr", 8'hFE, btn_m);

    BUTTONS = 4'b0001;
    repeat (SYNC + 1) tick_();
    btn_m[0] = 1'b1;
    check_rd("btn0_set", 8'hFE, btn_m);
    BUTTONS = 4'h0;
    repeat (SYNC + 2) tick_();
    BUTTONS = 4'b0001;
    repeat (SYNC) tick_();
    wr(8'h53, 8'h01);          // lands on the new edge
    check_rd("btn_edge_wins", 8'hFE, btn_m);
    wr(8'h53, 8'h01); btn_m[0] = 1'b0;
    check_rd("btn0_clr", 8'hFE, btn_m);
    BUTTONS = 4'h0;
    repeat (SYNC + 1) tick_();

    for (int i = 0; i < 4; i++) begin
      b = 4'($urandom_range(1, 15));
      BUTTONS = b;
      repeat (SYNC + 1) tick_();
      btn_m = btn_m | b;
      check_rd("btn_rnd_set", 8'hFE, btn_m);
      BUTTONS = 4'h0;
      repeat (SYNC + 1) tick_();
      c = 4'($urandom_range(0, 15));
      wr(8'h53, {4'h0, c});
      btn_m = btn_m & ~c;
      check_rd("btn_rnd_clr", 8'hFE, btn_m);
    end

`ifdef TIMER_PRESCALE_EN
    wr(8'h55, 8'h03);
    check_rd("pre_rd", 8'h55, 8'h03);
    wr(8'h50, 8'h01); wr(8'h51, 8'h00); wr(8'h52, 8'h01);
    wait_int(64, n);
    check("pre_lat", n, (1 + 1) * (3 + 1));
    wr(8'h52, 8'h04);
    wr(8'h55, 8'h00);
`endif

    // reset mid-count
    wr(8'h40, 8'h5A); wr(8'h41, 8'hC3);
    wr(8'h50, 8'h10); wr(8'h51, 8'h00); wr(8'h52, 8'h01);
    repeat (5) tick_();
    RESET = 1'b1;
    tick_();
    RESET = 1'b0;
    leds_m = 8'h00; sseg_m = 8'h00;
    check("mid_rst_leds", LEDS, leds_m);
    check("mid_rst_sseg", SSEG_DATA, sseg_m);
    check("mid_rst_int", bus.INT_R, 0);
    check_rd("mid_rst_status", 8'h52, 8'h00);
    check_rd("mid_rst_count", 8'h54, 8'h00);
    repeat (20) tick_();
    check("mid_rst_no_exp", bus.INT_R, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
